// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and defaults for the DIP-switch debouncer.
//   deb_state_t              : debouncer FSM state encoding
//   DEBOUNCE_CYCLES_DEFAULT  : 10 ms stability window at 100 MHz
//   SYNC_STAGES_DEFAULT      : two-flop synchronizer
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,  // accepted level is 0, input agrees
        CHK_HI = 2'd1,  // input went to 1, qualifying
        ST_HI  = 2'd2,  // accepted level is 1, input agrees
        CHK_LO = 2'd3   // input went to 0, qualifying
    } deb_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int SYNC_STAGES_DEFAULT     = 2;

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
// All stages clear to 0 on reset.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   i_d  : asynchronous input bit
//   o_q  : synchronized bit (output of the last stage)
// Parameters:
//   SYNC_STAGES : number of flops in the chain (>= 2)
// -----------------------------------------------------------------------------
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Stage 0 captures the raw input; each later stage copies its predecessor.
    assign sync_d[0] = i_d;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dip_debounce.sv
// -----------------------------------------------------------------------------
// dip_debounce
// Synchronizes and debounces a raw DIP-switch level. A new level is accepted
// only after the synchronized input has held it for DEBOUNCE_CYCLES cycles;
// any bounce during qualification restarts the count from zero.
// Ports:
//   clk    : 100 MHz system clock
//   rst    : synchronous active-high reset
//   i_dip  : raw, asynchronous, bouncy switch level
//   o_dip  : debounced level (registered)
//   o_rise : one-cycle pulse coincident with o_dip going 0->1
//   o_fall : one-cycle pulse coincident with o_dip going 1->0
// Parameters:
//   DEBOUNCE_CYCLES : stability window in cycles (>= 1)
//   SYNC_STAGES     : synchronizer depth (>= 2)
// Build option:
//   DIP_EDGE_PULSE_EN : when defined, o_rise/o_fall are generated; otherwise
//                       both are tied to 0 and no edge registers exist.
// Latency from input edge to o_dip change: SYNC_STAGES + DEBOUNCE_CYCLES + 1.
// -----------------------------------------------------------------------------
module dip_debounce
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dip,
    output logic o_dip,
    output logic o_rise,
    output logic o_fall
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which the pending level is accepted; the counter also
    // saturates here so it can never wrap.
    localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             o_dip_q, o_dip_d;
    logic             accept_rise;
    logic             accept_fall;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_dip),
        .o_q (s)
    );

    // Next-state logic. The first cycle s differs from the accepted level
    // enters the CHK state with cnt=0, so acceptance lands on the
    // DEBOUNCE_CYCLES+1-th edge after the change.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept_rise = 1'b0;
        accept_fall = 1'b0;

        case (state_q)
            ST_LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = '0;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = ST_LO;  // glitch: drop back silently
                end else if (cnt_q == CNT_TERM) begin
                    state_d     = ST_HI;
                    accept_rise = 1'b1;
                end else if (cnt_q < CNT_TERM) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = '0;
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = ST_HI;  // glitch: drop back silently
                end else if (cnt_q == CNT_TERM) begin
                    state_d     = ST_LO;
                    accept_fall = 1'b1;
                end else if (cnt_q < CNT_TERM) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Output level only moves on an accepted transition.
    always_comb begin
        o_dip_d = o_dip_q;
        if (accept_rise) begin
            o_dip_d = 1'b1;
        end else if (accept_fall) begin
            o_dip_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            o_dip_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_dip_q <= o_dip_d;
        end
    end

    assign o_dip = o_dip_q;

`ifdef DIP_EDGE_PULSE_EN
    // Pulses register the same acceptance condition as o_dip, so they are
    // aligned with the level change and mutually exclusive by construction.
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept_rise;
            fall_q <= accept_fall;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: doc/dip_debounce.md
# dip_debounce

Conditions the raw DIP-switch input before it reaches the lab top-level's `i_dip` port. The block synchronizes the asynchronous switch level into the `clk` domain and filters out contact bounce: a new level is accepted only after it has been stable for a programmable number of cycles. It outputs a clean level and, optionally, single-cycle edge pulses for downstream counters and LED logic.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive cycles the synchronized level must hold before it is accepted. The default is 10 ms at 100 MHz. Legal range is ≥ 1.
- `SYNC_STAGES`, default 2: number of synchronizer flops. Legal range is ≥ 2.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; one clock; synchronous, active-high.
- `i_dip`  in  1  raw switch level; asynchronous and bouncy.
- `o_dip`  out  1  debounced level, registered.
- `o_rise`  out  1  one-cycle pulse when `o_dip` goes 0→1.
- `o_fall`  out  1  one-cycle pulse when `o_dip` goes 1→0.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops. Call its last stage `s`. All stages reset to 0.
- Counter: width is `$clog2(DEBOUNCE_CYCLES+1)`. It is unsigned and never wraps; it saturates at its terminal value.
- FSM states: `ST_LO`, `CHK_HI`, `ST_HI`, `CHK_LO`.
- Transitions from `ST_LO`:
  - s=1 → `CHK_HI`, cnt←0.
  - Otherwise stay.
- Transitions from `CHK_HI`:
  - s=0 → `ST_LO`. This is a glitch: no output change and no pulse.
  - s=1 and cnt==DEBOUNCE_CYCLES-1 → `ST_HI`, o_dip←1, o_rise←1.
  - Otherwise cnt←cnt+1.
- `ST_HI` and `CHK_LO` mirror the above with levels inverted. Acceptance drives o_dip←0 and o_fall←1.
- `o_rise` and `o_fall` are high for exactly one cycle per accepted transition. They are never high at the same time and never high during reset.
- A bounce anywhere inside a CHK window restarts qualification from scratch. The next qualification begins again from cnt=0.
- Reset values: `o_dip`=0, `o_rise`=0, `o_fall`=0, state `ST_LO`, cnt=0.
  - A switch held at 1 through reset therefore produces one `o_rise` pulse after the full qualification latency once rst deasserts.
- Reset mid-qualification aborts the count. No pulse is emitted for the aborted transition.

## Timing
- Synchronizer latency: `SYNC_STAGES` cycles from the first clock edge that samples the new `i_dip` to `s` changing.
- Qualification latency: `o_dip` changes on the `DEBOUNCE_CYCLES+1`-th edge after `s` first differs from `o_dip`, provided `s` holds the whole time.
- Total latency, input edge to `o_dip` change: `SYNC_STAGES + DEBOUNCE_CYCLES + 1` clocks.
- `o_rise`/`o_fall` assert in the same cycle that `o_dip` changes.
- The minimum accepted pulse width on `i_dip` is `DEBOUNCE_CYCLES+1` cycles. Shorter pulses are invisible at the outputs.
- There is no combinational path from any input to any output.

## Configuration
- Macro `DIP_EDGE_PULSE_EN`.
- Defined: the `o_rise`/`o_fall` registers and logic are built as described above.
- Undefined: `o_rise` and `o_fall` are tied to constant 0 and no edge logic is synthesized. The ports remain present, and `o_dip` behaviour and latency are unchanged.

## Structure
- Package `debounce_pkg` holds:
  - the FSM state typedef `deb_state_t` (enum over the four states);
  - the localparam default for `DEBOUNCE_CYCLES`.
- Sub-module `bit_sync` holds the parameterized `SYNC_STAGES` flop chain. It has synchronous active-high reset to 0 and ports `clk`, `rst`, `i_d`, `o_q`. `dip_debounce` instantiates it once.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2, so total latency is 7 clocks.
- **Clean rise.** `i_dip` is 0 through reset and then held at 1. Expect `o_dip` to go 1 exactly 7 edges after the first sampling edge, with `o_rise` high for that single cycle and `o_fall` never high.
- **Bounce rejection.** Drive `i_dip` 1 for 3 cycles, 0 for 2 cycles, 1 for 3 cycles, then 0. Expect `o_dip` to stay 0 and no pulses.
- **Bounce then settle.** Drive `i_dip` 1 for 2 cycles, 0 for 1 cycle, then 1 permanently. Expect `o_dip` to rise 7 clocks after the final 0→1 edge.
- **Clean fall.** From an accepted 1, drop `i_dip` to 0 and hold. Expect `o_dip` to go 0 after 7 clocks with one `o_fall` pulse.
- **Reset mid-qualification.** With `i_dip`=1 held, assert `rst` for 1 cycle during `CHK_HI`.
  - Expect `o_dip`=0 and no pulse during reset.
  - Expect qualification to restart, with `o_dip` rising 7 clocks after rst deasserts.
- **Macro off.** Build without `DIP_EDGE_PULSE_EN` and rerun the clean-rise and clean-fall scenarios. Expect identical `o_dip` behaviour with `o_rise` and `o_fall` constantly 0.
